q_arbiter: RTL and testbench

Q_ARBITER -- requirements
Module: q_arbiter

---
 rtl/q_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_q_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/q_arbiter.sv
// q_arbiter: round-robin arbiter that time-shares one q_flop sampler between
// N requesters. The owner's data bit is driven into the q_flop. After a settle
// delay the sample strobe is raised. The synchronized ack is awaited with a
// timeout. The resolved value is returned to the owner with a one-cycle done
// pulse.
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   rst        in   asynchronous active-low reset
//   req        in   [N] per-requester sample request (level)
//   req_data   in   [N] per-requester data bit to resolve
//   grant      out  [N] one-hot current owner, zero when idle
//   done       out  [N] one-cycle pulse to the owner when result is valid
//   result     out  resolved value, valid while done is nonzero
//   timeout    out  pulse with done when the q_flop did not ack in time
//   busy       out  high in every state except IDLE
//   qf_data    out  data bit driven into the q_flop
//   qf_sample  out  sample strobe to the q_flop clock generator
//   qf_ack     in   q_flop ack (asynchronous)
//   qf_out     in   q_flop output (asynchronous)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate among req, starting at the round-robin pointer
// SETUP    | qf_data held stable for SETTLE cycles before sampling
// SAMPLE   | qf_sample high, waiting for ack_s or the TMO count
// CAPTURE  | one cycle: done/result/timeout presented to the owner
// RELEASE  | qf_sample low, waiting for ack_s to fall or the TMO count
module q_arbiter #(
    parameter int N      = 4,
    parameter int TMO    = 15,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] req_data,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic         result,
    output logic         timeout,
    output logic         busy,
    output logic         qf_data,
    output logic         qf_sample,
    input  logic         qf_ack,
    input  logic         qf_out
);

    localparam int CW = $clog2(TMO + 1);
    localparam int PW = $clog2(N);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SAMPLE,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_settle;
    logic          r_ack_1, r_ack_s;
    logic          r_out_1, r_out_s;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_done;
    logic          r_result;
    logic          r_timeout;
    logic          r_busy;
    logic          r_qf_data;
    logic          r_qf_sample;

    logic          w_found;
    logic [PW-1:0] w_pick;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_ptr_next;
    logic [N-1:0]  w_one;

    // First requester at or after r_ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_ptr_next = (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_one      = {{(N-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_settle    <= '0;
            r_ack_1     <= 1'b0;
            r_ack_s     <= 1'b0;
            r_out_1     <= 1'b0;
            r_out_s     <= 1'b0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_qf_data   <= 1'b0;
            r_qf_sample <= 1'b0;
        end else begin
            r_ack_1   <= qf_ack;
            r_ack_s   <= r_ack_1;
            r_out_1   <= qf_out;
            r_out_s   <= r_out_1;
            // done/result/timeout are single-cycle unless CAPTURE is being entered
            r_done    <= '0;
            r_result  <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_state   <= S_SETUP;
                        r_owner   <= w_pick;
                        r_grant   <= w_one << w_pick;
                        r_qf_data <= req_data[w_pick];
                        r_busy    <= 1'b1;
                        r_settle  <= 4'(SETTLE - 1);
                    end
                end
                S_SETUP: begin
                    if (r_settle == 4'd0) begin
                        r_state     <= S_SAMPLE;
                        r_qf_sample <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // ack wins over the timeout when both land on the same edge
                    if (r_ack_s || r_cnt == TMO_LAST) begin
                        r_state     <= S_CAPTURE;
                        r_qf_sample <= 1'b0;
                        r_cnt       <= '0;
                        r_done      <= r_grant;
                        r_result    <= r_ack_s ? r_out_s : 1'b0;
                        r_timeout   <= !r_ack_s;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_RELEASE;
                    r_cnt   <= '0;
                end
                S_RELEASE: begin
                    if (!r_ack_s || r_cnt == TMO_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_qf_data <= 1'b0;
                        r_ptr     <= w_ptr_next;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign result    = r_result;
    assign timeout   = r_timeout;
    assign busy      = r_busy;
    assign qf_data   = r_qf_data;
    assign qf_sample = r_qf_sample;

endmodule

// File: tb/tb_q_arbiter.sv
module tb_q_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] req_data = 4'b0000;
    logic [3:0] grant;
    logic [3:0] done;
    logic       result;
    logic       timeout;
    logic       busy;
    logic       qf_data;
    logic       qf_sample;
    logic       qf_ack = 1'b0;
    logic       qf_out = 1'b0;
    logic       ack_en = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_g [5];
    logic       exp_r [5];

    q_arbiter #(.N(4), .TMO(15), .SETTLE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .timeout   (timeout),
        .busy      (busy),
        .qf_data   (qf_data),
        .qf_sample (qf_sample),
        .qf_ack    (qf_ack),
        .qf_out    (qf_out)
    );

    always #5 clk = ~clk;

    // q_flop stand-in: ack follows qf_sample one cycle later (when enabled),
    // output follows qf_data.
    always @(posedge clk) begin
        qf_ack <= ack_en & qf_sample;
        qf_out <= qf_data;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done == 4'b0000 && n < 60) begin
            step(1);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done != 4'b0000), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            step(1);
            n++;
        end
        chk({tag, "_idle_seen"}, 32'(busy), 32'd0);
    endtask

    initial begin
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_r = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // reset state
        step(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_flags", 32'({result, timeout, busy, qf_data, qf_sample}), 32'h0);
        rst = 1'b1;
        step(1);

        // single request, ack one cycle after qf_sample
        req = 4'b0001; req_data = 4'b0001;
        step(1);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_qf_data", 32'(qf_data), 32'h1);
        step(1);
        chk("single_no_sample_setup", 32'(qf_sample), 32'h0);
        step(1);
        chk("single_sample", 32'(qf_sample), 32'h1);
        step(3);
        chk("single_not_yet_done", 32'(done), 32'h0);
        step(1);
        chk("single_done", 32'(done), 32'h1);
        chk("single_result", 32'(result), 32'h1);
        chk("single_timeout", 32'(timeout), 32'h0);
        chk("single_sample_low", 32'(qf_sample), 32'h0);
        req = 4'b0000;
        wait_idle("single");
        chk("single_grant_clear", 32'(grant), 32'h0);

        // round robin from ptr 0, all requesting
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        req = 4'b1111; req_data = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("rr%0d", k));
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(exp_g[k]));
            chk($sformatf("rr%0d_result", k), 32'(result), 32'(exp_r[k]));
            wait_idle($sformatf("rr%0d", k));
            chk($sformatf("rr%0d_gap_grant", k), 32'(grant), 32'h0);
            if (k == 4) req = 4'b0000;
        end

        // timeout: ack never arrives
        ack_en = 1'b0;
        req = 4'b0100; req_data = 4'b0100;
        step(1);
        chk("tmo_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        step(16);
        chk("tmo_not_yet", 32'(done), 32'h0);
        chk("tmo_still_sampling", 32'(qf_sample), 32'h1);
        step(1);
        chk("tmo_done", 32'(done), 32'h4);
        chk("tmo_flag", 32'(timeout), 32'h1);
        chk("tmo_result", 32'(result), 32'h0);
        step(1);
        chk("tmo_release", 32'({busy, done}), 32'h10);
        step(1);
        chk("tmo_release_exit", 32'({busy, grant}), 32'h0);

        // reset while sampling
        req = 4'b0010; req_data = 4'b0011;
        begin
            int n = 0;
            while (!qf_sample && n < 20) begin
                step(1);
                n++;
            end
        end
        chk("rstmid_sampling", 32'({qf_sample, qf_data}), 32'h3);
        rst = 1'b0;
        #1;
        chk("rstmid_async_outputs", 32'({grant, busy, qf_data, qf_sample}), 32'h0);
        req = 4'b1001;
        step(2);
        chk("rstmid_no_done", 32'({done, timeout, result}), 32'h0);
        rst = 1'b1;
        ack_en = 1'b1;
        step(1);
        chk("rstmid_ptr0_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        wait_done("rstmid");
        chk("rstmid_done", 32'(done), 32'h1);
        chk("rstmid_result", 32'(result), 32'h1);
        wait_idle("rstmid");

        // request dropped and data changed while busy
        req = 4'b0010; req_data = 4'b0010;
        step(1);
        chk("drop_grant", 32'(grant), 32'h2);
        chk("drop_qf_data", 32'(qf_data), 32'h1);
        req = 4'b0100; req_data = 4'b1101;
        step(1);
        chk("drop_qf_data_held", 32'(qf_data), 32'h1);
        chk("drop_grant_held", 32'(grant), 32'h2);
        wait_done("drop");
        chk("drop_done", 32'(done), 32'h2);
        chk("drop_result", 32'(result), 32'h1);
        wait_idle("drop");
        chk("drop_idle_grant", 32'(grant), 32'h0);
        step(1);
        chk("drop_next_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        wait_done("next");
        chk("next_done", 32'(done), 32'h4);
        wait_idle("next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
